// File: rtl/tug_field.sv
// rtl/tug_field.sv - tug-of-war playfield: moves a lit LED on press pulses, scores rounds, holds, ends match
module tug_field #(
  parameter int NUM_LEDS    = 9,
  parameter int SCORE_W     = 3,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                l_press,
  input  logic                r_press,
  output logic [NUM_LEDS-1:0] leds,
  output logic [SCORE_W-1:0]  l_score,
  output logic [SCORE_W-1:0]  r_score,
  output logic                l_win,
  output logic                r_win,
  output logic                game_over,
  output logic                winner_l
);

  localparam int POS_W  = $clog2(NUM_LEDS);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [POS_W-1:0]   CENTER    = POS_W'((NUM_LEDS - 1) / 2);
  localparam logic [POS_W-1:0]   LAST      = POS_W'(NUM_LEDS - 1);
  localparam logic [SCORE_W-1:0] MAX_SCORE = '1;
  localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLAY,
    S_HOLD,
    S_OVER
  } state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [SCORE_W-1:0] l_score_q, l_score_d;
  logic [SCORE_W-1:0] r_score_q, r_score_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               l_win_q, l_win_d;
  logic               r_win_q, r_win_d;
  logic               winner_l_q, winner_l_d;

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    l_score_d  = l_score_q;
    r_score_d  = r_score_q;
    hold_d     = hold_q;
    l_win_d    = 1'b0;
    r_win_d    = 1'b0;
    winner_l_d = winner_l_q;

    case (state_q)
      S_PLAY: begin
        // Simultaneous pulls cancel out, so only a lone press moves the marker.
        if (l_press && !r_press) begin
          if (pos_q == LAST) begin
            l_score_d = l_score_q + 1'b1;
            l_win_d   = 1'b1;
            if (l_score_d == MAX_SCORE) begin
              state_d    = S_OVER;
              winner_l_d = 1'b1;
            end else begin
              state_d = S_HOLD;
              hold_d  = HOLD_INIT;
            end
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else if (r_press && !l_press) begin
          if (pos_q == '0) begin
            r_score_d = r_score_q + 1'b1;
            r_win_d   = 1'b1;
            if (r_score_d == MAX_SCORE) begin
              state_d    = S_OVER;
              winner_l_d = 1'b0;
            end else begin
              state_d = S_HOLD;
              hold_d  = HOLD_INIT;
            end
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          state_d = S_PLAY;
          pos_d   = CENTER;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      S_OVER: begin
      end
      default: begin
        state_d = S_PLAY;
        pos_d   = CENTER;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_PLAY;
      pos_q      <= CENTER;
      l_score_q  <= '0;
      r_score_q  <= '0;
      hold_q     <= '0;
      l_win_q    <= 1'b0;
      r_win_q    <= 1'b0;
      winner_l_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      l_score_q  <= l_score_d;
      r_score_q  <= r_score_d;
      hold_q     <= hold_d;
      l_win_q    <= l_win_d;
      r_win_q    <= r_win_d;
      winner_l_q <= winner_l_d;
    end
  end

  always_comb begin
    leds = '0;
    case (state_q)
      S_PLAY:  leds = NUM_LEDS'(1) << pos_q;
      S_OVER:  leds = '1;
      default: leds = '0;
    endcase
  end

  assign l_score   = l_score_q;
  assign r_score   = r_score_q;
  assign l_win     = l_win_q;
  assign r_win     = r_win_q;
  assign game_over = (state_q == S_OVER);
  assign winner_l  = winner_l_q;

endmodule
